uart_rx_parity_checker: RTL and testbench

//  Sequential receive-side parity checker for the UART RX path: accumulates parity bit by bit as data bits arrive.

---
 rtl/uart_rx_parity_checker.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_parity_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parity_checker.sv
// Receive-side parity checker: assembles LSB-first data bits, accumulates
// their parity, checks the received parity bit against the frame's mode and
// reports per-frame error pulses plus a sticky flag and saturating counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no frame in progress; bit/parity strobes ignored
// COLLECT  | shifting in data bits, fewer than DATA_W received so far
// WAIT_PAR | all data bits received, waiting for the parity bit
module uart_rx_parity_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start_i,
  input  logic              bit_valid_i,
  input  logic              bit_in_i,
  input  logic              par_valid_i,
  input  logic              par_bit_i,
  input  logic              par_en_i,
  input  logic [1:0]        par_mode_i,
  input  logic              clr_err_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_valid_o,
  output logic              parity_error_o,
  output logic              len_error_o,
  output logic              err_sticky_o,
  output logic [CNT_W-1:0]  err_count_o
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_PAR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d, shreg_nxt;
  logic               acc_q, acc_d;
  logic [BW-1:0]      cnt_q, cnt_d;
  logic               par_en_q, par_en_d;
  logic [1:0]         par_mode_q, par_mode_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               parity_error_q, parity_error_d;
  logic               len_error_q, len_error_d;
  logic               err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               exp_par;
  logic               err_event;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      acc_q          <= 1'b0;
      cnt_q          <= '0;
      par_en_q       <= 1'b0;
      par_mode_q     <= 2'b00;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      len_error_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      par_en_q       <= par_en_d;
      par_mode_q     <= par_mode_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      len_error_q    <= len_error_d;
      err_sticky_q   <= err_sticky_d;
      err_count_q    <= err_count_d;
    end
  end

  // Expected parity for the mode latched at frame start
  always_comb begin
    exp_par = 1'b0;
    case (par_mode_q)
      2'b00:   exp_par = acc_q;
      2'b01:   exp_par = ~acc_q;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Next-state and pulse logic; frame_start outranks par_valid outranks bit_valid
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    par_en_d       = par_en_q;
    par_mode_d     = par_mode_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    len_error_d    = 1'b0;
    shreg_nxt      = {bit_in_i, shreg_q[DATA_W-1:1]};

    if (frame_start_i) begin
      // Restart from any state; an abandoned frame produces no pulses
      state_d    = COLLECT;
      shreg_d    = '0;
      acc_d      = 1'b0;
      cnt_d      = '0;
      par_en_d   = par_en_i;
      par_mode_d = par_mode_i;
    end else begin
      case (state_q)
        COLLECT: begin
          if (par_valid_i) begin
            len_error_d = 1'b1;
            state_d     = IDLE;
          end else if (bit_valid_i) begin
            shreg_d = shreg_nxt;
            acc_d   = acc_q ^ bit_in_i;
            cnt_d   = cnt_q + BW'(1);
            if (cnt_q == BW'(DATA_W - 1)) begin
              if (par_en_q) begin
                state_d = WAIT_PAR;
              end else begin
                data_out_d   = shreg_nxt;
                data_valid_d = 1'b1;
                state_d      = IDLE;
              end
            end
          end
        end
        WAIT_PAR: begin
          if (par_valid_i) begin
            data_out_d     = shreg_q;
            data_valid_d   = 1'b1;
            parity_error_d = (par_bit_i != exp_par);
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky flag and saturating counter; an error event wins over clr_err
  always_comb begin
    err_event    = parity_error_d | len_error_d;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (err_event) begin
      err_sticky_d = 1'b1;
      if (clr_err_i) begin
        err_count_d = CNT_W'(1);
      end else if (err_count_q != CNT_MAX) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end else if (clr_err_i) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  assign data_out_o     = data_out_q;
  assign data_valid_o   = data_valid_q;
  assign parity_error_o = parity_error_q;
  assign len_error_o    = len_error_q;
  assign err_sticky_o   = err_sticky_q;
  assign err_count_o    = err_count_q;

endmodule

// File: tb/tb_uart_rx_parity_checker.sv
// Scoreboard bench for uart_rx_parity_checker (DATA_W=8, CNT_W=2).
module tb_uart_rx_parity_checker;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic          clk;
  logic          rst_n;
  logic          frame_start_i, bit_valid_i, bit_in_i, par_valid_i, par_bit_i;
  logic          par_en_i, clr_err_i;
  logic [1:0]    par_mode_i;
  logic [DW-1:0] data_out_o;
  logic          data_valid_o, parity_error_o, len_error_o, err_sticky_o;
  logic [CW-1:0] err_count_o;

  uart_rx_parity_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start_i  (frame_start_i),
    .bit_valid_i    (bit_valid_i),
    .bit_in_i       (bit_in_i),
    .par_valid_i    (par_valid_i),
    .par_bit_i      (par_bit_i),
    .par_en_i       (par_en_i),
    .par_mode_i     (par_mode_i),
    .clr_err_i      (clr_err_i),
    .data_out_o     (data_out_o),
    .data_valid_o   (data_valid_o),
    .parity_error_o (parity_error_o),
    .len_error_o    (len_error_o),
    .err_sticky_o   (err_sticky_o),
    .err_count_o    (err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_data;
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int            m_cnt = 0;
  logic          m_sticky = 1'b0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void note_error_cycle(input logic is_err, input logic clr);
    if (is_err) begin
      m_sticky = 1'b1;
      m_cnt    = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end
  endfunction

  function automatic logic ref_parity(input logic [DW-1:0] d, input logic [1:0] mode);
    int ones;
    ones = $countones(d);
    case (mode)
      2'b00:   return logic'(ones % 2);
      2'b01:   return logic'(1 - (ones % 2));
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (data_valid_o || len_error_o || parity_error_o)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, data_valid_o, parity_error_o, len_error_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.is_data) begin
          chk("data_valid", 32'(data_valid_o), 32'd1);
          chk("data_out", 32'(data_out_o), 32'(e.data));
          chk("parity_error", 32'(parity_error_o), 32'(e.perr));
          chk("len_error_quiet", 32'(len_error_o), 32'd0);
        end else begin
          chk("len_error", 32'(len_error_o), 32'd1);
          chk("no_valid_on_len", 32'(data_valid_o), 32'd0);
          chk("no_perr_on_len", 32'(parity_error_o), 32'd0);
        end
      end
    end
  end

  task automatic idle_inputs();
    frame_start_i = 1'b0;
    bit_valid_i   = 1'b0;
    bit_in_i      = 1'b0;
    par_valid_i   = 1'b0;
    par_bit_i     = 1'b0;
    clr_err_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, "_err_count"}, 32'(err_count_o), 32'(m_cnt));
    chk({tag, "_err_sticky"}, 32'(err_sticky_o), 32'(m_sticky));
    chk({tag, "_data_hold"}, 32'(data_out_o), 32'(m_data));
  endtask

  task automatic clear_errors();
    clr_err_i = 1'b1;
    note_error_cycle(1'b0, 1'b1);
    tick();
  endtask

  // Drives one frame; nbits data bits, then optionally a parity strobe
  task automatic frame(input logic [DW-1:0] d, input int nbits, input logic pen,
                       input logic [1:0] mode, input logic send_par, input logic pbit,
                       input logic clr);
    exp_t e;
    logic perr;
    frame_start_i = 1'b1;
    par_en_i      = pen;
    par_mode_i    = mode;
    tick();
    for (int i = 0; i < nbits; i++) begin
      // mid-frame config changes must not matter
      par_en_i    = 1'($urandom);
      par_mode_i  = 2'($urandom);
      bit_valid_i = 1'b1;
      bit_in_i    = d[i];
      if (i == DW - 1 && !pen) begin
        e.is_data = 1'b1; e.data = d; e.perr = 1'b0;
        sb_q.push_back(e);
        m_data = d;
      end
      tick();
    end
    if (send_par) begin
      par_valid_i = 1'b1;
      par_bit_i   = pbit;
      clr_err_i   = clr;
      bit_valid_i = 1'($urandom);
      bit_in_i    = 1'($urandom);
      if (nbits < DW) begin
        e.is_data = 1'b0; e.data = '0; e.perr = 1'b0;
        sb_q.push_back(e);
        note_error_cycle(1'b1, clr);
      end else if (pen) begin
        perr = (pbit != ref_parity(d, mode));
        e.is_data = 1'b1; e.data = d; e.perr = perr;
        sb_q.push_back(e);
        m_data = d;
        note_error_cycle(perr, clr);
      end else begin
        note_error_cycle(1'b0, clr);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    par_en_i   = 1'b0;
    par_mode_i = 2'b00;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", 32'(data_out_o), 32'd0);
    chk("rst_pulses", {29'd0, data_valid_o, parity_error_o, len_error_o}, 32'd0);
    chk("rst_sticky", 32'(err_sticky_o), 32'd0);
    chk("rst_count", 32'(err_count_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Stray strobes in IDLE are ignored
    bit_valid_i = 1'b1; bit_in_i = 1'b1; tick();
    par_valid_i = 1'b1; tick();
    check_status("idle_stray");

    frame(8'hA5, DW, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    check_status("even_ok");
    frame(8'hA5, DW, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    check_status("odd_err");
    frame(8'h5A, DW, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    check_status("mark_err");
    frame(8'h5A, DW, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    check_status("space_ok");
    frame(8'h3C, DW, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check_status("nopar");
    frame(8'h00, 5, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    check_status("len_err");

    clear_errors();
    check_status("cleared");
    for (int k = 0; k < 4; k++) frame(8'hA5, DW, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    check_status("saturate");
    frame(8'hA5, DW, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    check_status("clr_vs_event");

    // Abandoned frame: restart mid-frame without pulses
    frame(8'h77, 6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    frame(8'h81, DW, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    check_status("restart");

    // Reset in the middle of a frame
    frame(8'hFF, 4, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    m_cnt = 0; m_sticky = 1'b0; m_data = '0;
    @(negedge clk);
    chk("midrst_data_out", 32'(data_out_o), 32'd0);
    chk("midrst_pulses", {29'd0, data_valid_o, parity_error_o, len_error_o}, 32'd0);
    chk("midrst_sticky", 32'(err_sticky_o), 32'd0);
    chk("midrst_count", 32'(err_count_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    frame(8'hFF, DW, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    check_status("after_rst");

    // Randomized frames
    for (int n = 0; n < 80; n++) begin
      logic [DW-1:0] d;
      int            nb;
      d  = 8'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DW - 1) : DW;
      frame(d, nb, 1'($urandom), 2'($urandom), ($urandom_range(0, 5) != 0),
            1'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) tick();
      if ($urandom_range(0, 9) == 0) clear_errors();
      check_status("rand");
    end

    repeat (4) tick();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
